record_sequencer: RTL and testbench
===================================

Name: record_sequencer

Overview:
- Central controller for the note-recording subsystem. It sequences one shared 12-bit-wide sample memory, holding one bit per note: C D E F G A B C# D# F# G# A#.
- Turns record, play and stop button requests into a RECORD/PLAY/IDLE state machine. Generates the sample tick, the memory address and the write strobe, tracks the recorded length, and drives playback notes to the synth path.
- Sits between the keyboard/button decode and the synth, replacing per-note record/playback gating with one sequenced bank.

Parameters:
TICK_DIV, 500000, clock cycles per sample period (100 Hz at 50 MHz); must be >= 2
ADDR_W, 12, sample memory address width; depth = 2^ADDR_W
LOOP, 0, 1 = playback wraps to address 0 at end; 0 = playback stops at end

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
active  in  1  recording subsystem enabled; 0 aborts any operation
rec_req  in  1  record button level, active-high
play_req  in  1  playback button level, active-high
stop_req  in  1  stop button level, active-high
notes_in  in  12  live note levels to record
mem_rdata  in  12  memory read data; synchronous read, 1-cycle latency
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write strobe (one cycle per sample)
mem_wdata  out  12  memory write data
notes_out  out  12  playback note levels (registered)
recording  out  1  high in RECORD
playing  out  1  high in PLAY
length  out  ADDR_W+1  samples recorded, 0..2^ADDR_W
full  out  1  last recording filled memory

Behaviour:
- Reset (sync, active-high) values:
  - state IDLE.
  - mem_addr, mem_we, mem_wdata, notes_out, length, full, tick counter all 0.
  - recording and playing 0.
  - Edge-detect registers 0.
  - Reset mid-RECORD or mid-PLAY discards the recording: length returns to 0.
- Request edges:
  - prev_x <= x_req each cycle; x_rise = x_req & ~prev_x.
  - A held button acts once.
  - All rises are ignored while active=0.
- Tick:
  - Counter runs 0..TICK_DIV-1 and asserts tick when it equals TICK_DIV-1.
  - The counter clears on every state transition, so the first tick comes TICK_DIV cycles after entry.
- IDLE:
  - rec_rise: go to RECORD; mem_addr<=0, length<=0, full<=0.
  - Otherwise play_rise with length!=0: go to PLAY; mem_addr<=0, done<=0.
  - play_rise with length==0 is ignored.
  - Simultaneous rec_rise and play_rise: record wins.
- RECORD:
  - On tick: mem_we=1 for exactly that cycle, mem_wdata=notes_in, length<=mem_addr+1.
  - If mem_addr==2^ADDR_W-1: full<=1 and go to IDLE. Otherwise mem_addr<=mem_addr+1.
  - stop_rise or rec_rise: go to IDLE, keeping length. A tick in the same cycle still writes first.
  - play_rise is ignored.
  - mem_we is never asserted outside RECORD.
- PLAY:
  - mem_addr is held for the whole tick period, so mem_rdata is valid from the second cycle onward.
  - On tick with done=0: notes_out<=mem_rdata.
    - If mem_addr==length-1: with LOOP=1, mem_addr<=0; with LOOP=0, done<=1.
    - Otherwise mem_addr<=mem_addr+1.
  - On tick with done=1: go to IDLE, notes_out<=0. The last sample is therefore held a full period.
  - stop_rise or play_rise: go to IDLE, notes_out<=0 the next cycle.
  - rec_rise is ignored.
- Leaving PLAY by any route: notes_out is cleared.
- active=0 in RECORD or PLAY:
  - Go to IDLE next cycle and clear notes_out.
  - length keeps the samples written so far.
- recording = (state==RECORD); playing = (state==PLAY); both registered.
- mem_addr returns to 0 on every entry to IDLE.

Test Plan:
- Setup for all scenarios: TICK_DIV=4, ADDR_W=3, LOOP=0, active=1.
- Reset, then pulse rec_req 1 cycle, hold notes_in=12'h001 then 12'h002 then 12'h004 across three ticks, then pulse stop_req -> mem_we pulses at cycles 4, 8, 12 after entry with addr 0, 1, 2 and the matching data; recording=1 throughout; length=3; full=0.
- Then pulse play_req, with the memory model returning the written data -> notes_out=001, 002, 004 each held 4 cycles, then 000; playing falls 4 cycles after the last sample; mem_we stays 0.
- Record for 9+ ticks without stop -> 8 writes (addr 0..7), auto return to IDLE, length=8, full=1, no 9th write.
- LOOP=1, length=3, play for 7 ticks -> notes_out sequence addr 0,1,2,0,1,2,0; stop_req -> notes_out=0 and IDLE.
- From IDLE, rec_req and play_req rise in the same cycle -> RECORD entered. Holding rec_req high 20 cycles -> single transition only.
- Drop active mid-PLAY -> IDLE and notes_out=0 next cycle, length unchanged. Assert reset mid-RECORD -> all outputs 0, length=0; a subsequent play_req is ignored.

Source files
------------

// File: rtl/record_sequencer.sv
// Sequencer for the shared note-sample memory: turns record/play/stop buttons into
// a RECORD/PLAY/IDLE machine driving the memory address, write strobe and playback notes.
module record_sequencer #(
    parameter int TICK_DIV = 500000,
    parameter int ADDR_W   = 12,
    parameter bit LOOP     = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              active,
    input  logic              rec_req,
    input  logic              play_req,
    input  logic              stop_req,
    input  logic [11:0]       notes_in,
    input  logic [11:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [11:0]       mem_wdata,
    output logic [11:0]       notes_out,
    output logic              recording,
    output logic              playing,
    output logic [ADDR_W:0]   length,
    output logic              full
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_PLAY   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     length_q, length_d;
    logic                full_q, full_d;
    logic                done_q, done_d;
    logic [11:0]         notes_q, notes_d;
    logic                recording_q, playing_q;
    logic                prev_rec_q, prev_play_q, prev_stop_q;
    logic                rec_rise_s, play_rise_s, stop_rise_s;
    logic                tick_s;
    logic                we_s;

    assign rec_rise_s  = rec_req  & ~prev_rec_q  & active;
    assign play_rise_s = play_req & ~prev_play_q & active;
    assign stop_rise_s = stop_req & ~prev_stop_q & active;
    assign tick_s      = (cnt_q == CNT_LAST);

    // Next-state, address, length and playback-note logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        length_d = length_q;
        full_d   = full_q;
        done_d   = done_q;
        notes_d  = notes_q;
        we_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rec_rise_s) begin
                    state_d  = S_RECORD;
                    length_d = '0;
                    full_d   = 1'b0;
                end else if (play_rise_s && (length_q != '0)) begin
                    state_d = S_PLAY;
                    done_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RECORD: begin
                if (!active) begin
                    state_d = S_IDLE;
                end else begin
                    if (tick_s) begin
                        we_s     = 1'b1;
                        length_d = {1'b0, addr_q} + (ADDR_W+1)'(1);
                        if (addr_q == ADDR_MAX) begin
                            full_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end else begin
                        we_s = 1'b0;
                    end
                    // A stop in the same cycle as a tick still lets that sample be written.
                    if (stop_rise_s || rec_rise_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = state_d;
                    end
                end
            end
            S_PLAY: begin
                if (!active || stop_rise_s || play_rise_s) begin
                    state_d = S_IDLE;
                end else if (tick_s) begin
                    if (done_q) begin
                        state_d = S_IDLE;
                    end else begin
                        notes_d = mem_rdata;
                        if ({1'b0, addr_q} == (length_q - (ADDR_W+1)'(1))) begin
                            if (LOOP) begin
                                addr_d = '0;
                            end else begin
                                done_d = 1'b1;
                            end
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end
                end else begin
                    state_d = S_PLAY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Every state entry starts from address 0; notes only sound while playing.
        if (state_d != state_q) begin
            addr_d = '0;
        end else begin
            addr_d = addr_d;
        end
        if (state_d != S_PLAY) begin
            notes_d = 12'h000;
        end else begin
            notes_d = notes_d;
        end
        if ((state_d != state_q) || tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, counter, edge-detect and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            length_q    <= '0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            notes_q     <= 12'h000;
            recording_q <= 1'b0;
            playing_q   <= 1'b0;
            prev_rec_q  <= 1'b0;
            prev_play_q <= 1'b0;
            prev_stop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            length_q    <= length_d;
            full_q      <= full_d;
            done_q      <= done_d;
            notes_q     <= notes_d;
            recording_q <= (state_d == S_RECORD);
            playing_q   <= (state_d == S_PLAY);
            prev_rec_q  <= rec_req;
            prev_play_q <= play_req;
            prev_stop_q <= stop_req;
        end
    end

    // The strobe must coincide with the address it writes, so it is decoded from the
    // current state and tick rather than registered one cycle late.
    assign mem_we    = we_s;
    assign mem_wdata = we_s ? notes_in : 12'h000;
    assign mem_addr  = addr_q;
    assign notes_out = notes_q;
    assign recording = recording_q;
    assign playing   = playing_q;
    assign length    = length_q;
    assign full      = full_q;

endmodule

// File: tb/tb_record_sequencer.sv
// Self-checking bench for record_sequencer: directed scenarios plus random stimulus
// against a cycle-level behavioural model, for a LOOP=0 and a LOOP=1 instance.
module tb_record_sequencer;

    localparam int TD    = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int S_IDLE = 0, S_REC = 1, S_PLAY = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, active, rec_req, play_req, stop_req;
    logic [11:0] notes_in;
    logic [11:0] rdata_a [2];
    logic [AW-1:0] addr_a [2];
    logic        we_a [2];
    logic [11:0] wdata_a [2];
    logic [11:0] notes_a [2];
    logic        rec_a [2];
    logic        ply_a [2];
    logic [AW:0] len_a [2];
    logic        full_a [2];
    logic [11:0] mem [2][DEPTH];

    int errors = 0;
    int checks = 0;

    record_sequencer #(.TICK_DIV(TD), .ADDR_W(AW), .LOOP(1'b0)) dut0 (
        .clock(clock), .reset(reset), .active(active), .rec_req(rec_req),
        .play_req(play_req), .stop_req(stop_req), .notes_in(notes_in),
        .mem_rdata(rdata_a[0]), .mem_addr(addr_a[0]), .mem_we(we_a[0]),
        .mem_wdata(wdata_a[0]), .notes_out(notes_a[0]), .recording(rec_a[0]),
        .playing(ply_a[0]), .length(len_a[0]), .full(full_a[0]));

    record_sequencer #(.TICK_DIV(TD), .ADDR_W(AW), .LOOP(1'b1)) dut1 (
        .clock(clock), .reset(reset), .active(active), .rec_req(rec_req),
        .play_req(play_req), .stop_req(stop_req), .notes_in(notes_in),
        .mem_rdata(rdata_a[1]), .mem_addr(addr_a[1]), .mem_we(we_a[1]),
        .mem_wdata(wdata_a[1]), .notes_out(notes_a[1]), .recording(rec_a[1]),
        .playing(ply_a[1]), .length(len_a[1]), .full(full_a[1]));

    // Synchronous-read sample memories, one per instance.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (we_a[i]) mem[i][addr_a[i]] <= wdata_a[i];
            rdata_a[i] <= mem[i][addr_a[i]];
        end
    end

    // Behavioural model: age = cycles spent in the current state since entry.
    int          m_st [2];
    int          m_age [2];
    int          m_addr [2];
    int          m_len [2];
    bit          m_full [2];
    bit          m_done [2];
    logic [11:0] m_notes [2];
    logic [11:0] m_mem [2][DEPTH];
    bit          p_rec, p_play, p_stop;

    function automatic bit m_tick(int i);
        return (m_age[i] % TD) == (TD - 1);
    endfunction

    function automatic bit m_we(int i);
        return (m_st[i] == S_REC) && active && m_tick(i);
    endfunction

    task automatic model_update();
        bit rr, pr, sr, tk;
        int nst;
        rr = rec_req && !p_rec && active;
        pr = play_req && !p_play && active;
        sr = stop_req && !p_stop && active;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_st[i] = S_IDLE; m_age[i] = 0; m_addr[i] = 0; m_len[i] = 0;
                m_full[i] = 0; m_done[i] = 0; m_notes[i] = 12'h000;
            end else begin
                tk = m_tick(i);
                nst = m_st[i];
                case (m_st[i])
                    S_IDLE: begin
                        if (rr) begin
                            nst = S_REC; m_len[i] = 0; m_full[i] = 0;
                        end else if (pr && m_len[i] != 0) begin
                            nst = S_PLAY; m_done[i] = 0;
                        end
                    end
                    S_REC: begin
                        if (!active) nst = S_IDLE;
                        else begin
                            if (tk) begin
                                m_mem[i][m_addr[i]] = notes_in;
                                m_len[i] = m_addr[i] + 1;
                                if (m_addr[i] == DEPTH - 1) begin
                                    m_full[i] = 1; nst = S_IDLE;
                                end else m_addr[i]++;
                            end
                            if (sr || rr) nst = S_IDLE;
                        end
                    end
                    S_PLAY: begin
                        if (!active || sr || pr) nst = S_IDLE;
                        else if (tk) begin
                            if (m_done[i]) nst = S_IDLE;
                            else begin
                                m_notes[i] = m_mem[i][m_addr[i]];
                                if (m_addr[i] == m_len[i] - 1) begin
                                    if (i == 1) m_addr[i] = 0;
                                    else m_done[i] = 1;
                                end else m_addr[i]++;
                            end
                        end
                    end
                    default: nst = S_IDLE;
                endcase
                if (nst != m_st[i]) begin
                    m_age[i] = 0; m_addr[i] = 0;
                end else m_age[i]++;
                if (nst != S_PLAY) m_notes[i] = 12'h000;
                m_st[i] = nst;
            end
        end
        p_rec  = reset ? 1'b0 : rec_req;
        p_play = reset ? 1'b0 : play_req;
        p_stop = reset ? 1'b0 : stop_req;
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (addr_a[i] !== 3'd0 || we_a[i] !== 1'b0 || wdata_a[i] !== 12'h000 ||
                notes_a[i] !== 12'h000 || rec_a[i] !== 1'b0 || ply_a[i] !== 1'b0 ||
                len_a[i] !== 4'd0 || full_a[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d: addr=%0d we=%b wdata=%h notes=%h rec=%b ply=%b len=%0d full=%b, required all zero",
                         i, addr_a[i], we_a[i], wdata_a[i], notes_a[i], rec_a[i], ply_a[i], len_a[i], full_a[i]);
            end
        end
    endtask

    task automatic test_record();
        rec_req = 1'b1; step(); rec_req = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            notes_in = 12'h001 << (k / 4);
            #1;
            checks++;
            if (rec_a[0] !== 1'b1) begin
                errors++; $display("FAIL rec_level k=%0d: got %b required 1", k, rec_a[0]);
            end
            checks++;
            if (we_a[0] !== ((k % 4) == 3)) begin
                errors++; $display("FAIL rec_we k=%0d: got %b required %b", k, we_a[0], (k % 4) == 3);
            end
            if ((k % 4) == 3) begin
                checks++;
                if (addr_a[0] !== 3'(k / 4) || wdata_a[0] !== (12'h001 << (k / 4))) begin
                    errors++;
                    $display("FAIL rec_write k=%0d: addr=%0d data=%h required addr=%0d data=%h",
                             k, addr_a[0], wdata_a[0], k / 4, 12'h001 << (k / 4));
                end
            end
        end
        stop_req = 1'b1; step(); stop_req = 1'b0;
        checks++;
        if (rec_a[0] !== 1'b0 || len_a[0] !== 4'd3 || full_a[0] !== 1'b0 || addr_a[0] !== 3'd0) begin
            errors++;
            $display("FAIL rec_stop: rec=%b len=%0d full=%b addr=%0d required rec=0 len=3 full=0 addr=0",
                     rec_a[0], len_a[0], full_a[0], addr_a[0]);
        end
    endtask

    task automatic test_play();
        logic [11:0] exp_n;
        play_req = 1'b1; step(); play_req = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_n = (k < 4) ? 12'h000 : (k < 8) ? 12'h001 : (k < 12) ? 12'h002 :
                    (k < 16) ? 12'h004 : 12'h000;
            checks++;
            if (notes_a[0] !== exp_n || ply_a[0] !== (k < 16) || we_a[0] !== 1'b0) begin
                errors++;
                $display("FAIL play_seq k=%0d: notes=%h ply=%b we=%b required notes=%h ply=%b we=0",
                         k, notes_a[0], ply_a[0], we_a[0], exp_n, k < 16);
            end
        end
    endtask

    task automatic test_loop();
        logic [11:0] seq [7];
        seq = '{12'h001, 12'h002, 12'h004, 12'h001, 12'h002, 12'h004, 12'h001};
        stop_req = 1'b1; step(); stop_req = 1'b0;
        play_req = 1'b1; step(); play_req = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            step();
            checks++;
            if (notes_a[1] !== ((k < 4) ? 12'h000 : seq[k / 4 - 1]) || ply_a[1] !== 1'b1) begin
                errors++;
                $display("FAIL loop_seq k=%0d: notes=%h ply=%b required notes=%h ply=1",
                         k, notes_a[1], ply_a[1], (k < 4) ? 12'h000 : seq[k / 4 - 1]);
            end
        end
        stop_req = 1'b1; step(); stop_req = 1'b0;
        checks++;
        if (notes_a[1] !== 12'h000 || ply_a[1] !== 1'b0) begin
            errors++;
            $display("FAIL loop_stop: notes=%h ply=%b required 000/0", notes_a[1], ply_a[1]);
        end
    endtask

    task automatic test_full();
        int writes = 0;
        rec_req = 1'b1; step(); rec_req = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            notes_in = 12'($urandom);
            #1;
            checks++;
            if (we_a[0] !== (((k % 4) == 3) && k < 32) || rec_a[0] !== (k < 32)) begin
                errors++;
                $display("FAIL full_we k=%0d: we=%b rec=%b required we=%b rec=%b",
                         k, we_a[0], rec_a[0], ((k % 4) == 3) && k < 32, k < 32);
            end
            if (we_a[0] === 1'b1) begin
                checks++;
                if (addr_a[0] !== 3'(writes) || wdata_a[0] !== notes_in) begin
                    errors++;
                    $display("FAIL full_write k=%0d: addr=%0d data=%h required addr=%0d data=%h",
                             k, addr_a[0], wdata_a[0], writes, notes_in);
                end
                writes++;
            end
        end
        checks++;
        if (writes != 8 || len_a[0] !== 4'd8 || full_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL full_end: writes=%0d len=%0d full=%b required 8/8/1", writes, len_a[0], full_a[0]);
        end
    endtask

    task automatic test_simultaneous();
        rec_req = 1'b1; play_req = 1'b1; step();
        checks++;
        if (rec_a[0] !== 1'b1 || ply_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL simul_rec: rec=%b ply=%b required 1/0", rec_a[0], ply_a[0]);
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if (rec_a[0] !== 1'b1) begin
                errors++; $display("FAIL held_rec k=%0d: rec=%b required 1", k, rec_a[0]);
            end
        end
        rec_req = 1'b0; play_req = 1'b0;
        stop_req = 1'b1; step(); stop_req = 1'b0;
        checks++;
        if (rec_a[0] !== 1'b0 || len_a[0] !== 4'd5 || full_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL held_stop: rec=%b len=%0d full=%b required 0/5/0", rec_a[0], len_a[0], full_a[0]);
        end
    endtask

    task automatic test_active_drop();
        play_req = 1'b1; step(); play_req = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        checks++;
        if (ply_a[0] !== 1'b1) begin
            errors++; $display("FAIL drop_pre: ply=%b required 1", ply_a[0]);
        end
        active = 1'b0; step();
        checks++;
        if (ply_a[0] !== 1'b0 || notes_a[0] !== 12'h000 || len_a[0] !== 4'd5) begin
            errors++;
            $display("FAIL drop_idle: ply=%b notes=%h len=%0d required 0/000/5", ply_a[0], notes_a[0], len_a[0]);
        end
        active = 1'b1; step();
    endtask

    task automatic test_reset_mid_record();
        rec_req = 1'b1; step(); rec_req = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        reset = 1'b1; step(); reset = 1'b0;
        #1;
        checks++;
        if (addr_a[0] !== 3'd0 || we_a[0] !== 1'b0 || wdata_a[0] !== 12'h000 ||
            notes_a[0] !== 12'h000 || rec_a[0] !== 1'b0 || ply_a[0] !== 1'b0 ||
            len_a[0] !== 4'd0 || full_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL midrec_reset: addr=%0d we=%b rec=%b len=%0d full=%b required all zero",
                     addr_a[0], we_a[0], rec_a[0], len_a[0], full_a[0]);
        end
        play_req = 1'b1; step(); play_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (ply_a[0] !== 1'b0) begin
                errors++; $display("FAIL empty_play k=%0d: ply=%b required 0", k, ply_a[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 2000; n++) begin
            rec_req  = ($urandom_range(99) < 5);
            play_req = ($urandom_range(99) < 5);
            stop_req = ($urandom_range(99) < 3);
            active   = ($urandom_range(99) >= 3);
            reset    = ($urandom_range(299) == 0);
            notes_in = 12'($urandom);
            #1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rec_a[i] !== (m_st[i] == S_REC) || ply_a[i] !== (m_st[i] == S_PLAY) ||
                    addr_a[i] !== m_addr[i][AW-1:0] || notes_a[i] !== m_notes[i] ||
                    len_a[i] !== m_len[i][AW:0] || full_a[i] !== m_full[i] ||
                    we_a[i] !== m_we(i) || wdata_a[i] !== (m_we(i) ? notes_in : 12'h000)) begin
                    errors++;
                    $display("FAIL random n=%0d dut%0d: rec=%b ply=%b addr=%0d notes=%h len=%0d full=%b we=%b wd=%h required rec=%b ply=%b addr=%0d notes=%h len=%0d full=%b we=%b",
                             n, i, rec_a[i], ply_a[i], addr_a[i], notes_a[i], len_a[i], full_a[i],
                             we_a[i], wdata_a[i], m_st[i] == S_REC, m_st[i] == S_PLAY, m_addr[i],
                             m_notes[i], m_len[i], m_full[i], m_we(i));
                end
            end
            step();
        end
        reset = 1'b0; active = 1'b1;
        rec_req = 1'b0; play_req = 1'b0; stop_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; active = 1'b1;
        rec_req = 1'b0; play_req = 1'b0; stop_req = 1'b0;
        notes_in = 12'h000;
        p_rec = 1'b0; p_play = 1'b0; p_stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rdata_a[i] = 12'h000;
            m_st[i] = S_IDLE; m_age[i] = 0; m_addr[i] = 0; m_len[i] = 0;
            m_full[i] = 0; m_done[i] = 0; m_notes[i] = 12'h000;
            for (int a = 0; a < DEPTH; a++) begin
                mem[i][a] = 12'h000;
                m_mem[i][a] = 12'h000;
            end
        end
        test_reset();
        test_record();
        test_play();
        test_loop();
        test_full();
        test_simultaneous();
        test_active_drop();
        test_reset_mid_record();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
